multicycle_control: RTL and testbench

- Moore/Mealy finite-state sequencer for the multicycle CPU datapath.
- Decodes the 6-bit opcode of the instruction register and steps fetch/decode/execute/memory/writeback one state per cycle, stalling on memory handshakes.
- Drives the datapath write enables and the one-hot mux-select vectors that the downstream select encoders compress into binary mux controls.
- Also keeps a retired-instruction counter for debug.

---
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU control sequencer: one state per cycle through fetch/decode/execute/memory/writeback,
// stalling on memory handshakes, with one-hot datapath selects and a retired-instruction counter.
module multicycle_control #(
   parameter int COUNT_W = 16
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [5:0]         Opcode,
   input  logic               Zero,
   input  logic               MemReady,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic               IorD,
   output logic               MemToReg,
   output logic [3:0]         ALUSrcBSel,
   output logic [2:0]         PCSrcSel,
   output logic [2:0]         RegDstSel,
   output logic [2:0]         ALUOpSel,
   output logic [3:0]         State,
   output logic               Illegal,
   output logic [COUNT_W-1:0] RetireCount
);

   typedef enum logic [3:0] {
      S_INIT    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADDR = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_IEXEC   = 4'd11,
      S_IWB     = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_e               state_q, state_d;
   logic [COUNT_W-1:0]   retire_q, retire_d;
   logic                 retire;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_INIT;
         retire_q <= '0;
      end else begin
         state_q  <= state_d;
         retire_q <= retire_d;
      end
   end

   assign retire_d = retire ? retire_q + COUNT_W'(1) : retire_q;

   // NOTE: every output and next-state signal gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IorD       = 1'b0;
      MemToReg   = 1'b0;
      ALUSrcBSel = 4'b0000;
      PCSrcSel   = 3'b000;
      RegDstSel  = 3'b000;
      ALUOpSel   = 3'b000;
      Illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            MemRead    = 1'b1;
            ALUSrcBSel = 4'b0010;
            ALUOpSel   = 3'b001;
            PCSrcSel   = 3'b001;
            PCWrite    = MemReady;
            IRWrite    = MemReady;
            if (MemReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcBSel = 4'b1000;
            ALUOpSel   = 3'b001;
            case (Opcode)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_IEXEC;
               default: begin
                  state_d = S_FETCH;
                  Illegal = 1'b1;
               end
            endcase
         end
         S_MEMADDR: begin
            ALUSrcBSel = 4'b0100;
            ALUOpSel   = 3'b001;
            state_d    = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (MemReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite  = 1'b1;
            MemToReg  = 1'b1;
            RegDstSel = 3'b001;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (MemReady) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            ALUSrcBSel = 4'b0001;
            ALUOpSel   = 3'b100;
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite  = 1'b1;
            RegDstSel = 3'b010;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcBSel = 4'b0001;
            ALUOpSel   = 3'b010;
            PCSrcSel   = 3'b010;
            PCWrite    = Zero;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_JUMP: begin
            PCSrcSel = 3'b100;
            PCWrite  = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_IEXEC: begin
            ALUSrcBSel = 4'b0100;
            ALUOpSel   = 3'b001;
            state_d    = S_IWB;
         end
         S_IWB: begin
            RegWrite  = 1'b1;
            RegDstSel = 3'b001;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         // INIT and the unused encodings 13-15 all drive zeros and restart at FETCH.
         default: state_d = S_FETCH;
      endcase
   end

   assign State       = state_q;
   assign RetireCount = retire_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level path model checked every cycle,
// plus hand-computed state sequences, select values and retire counts.
module tb_multicycle_control;

   localparam int CW = 8;

   logic          Clock = 1'b0;
   logic          Reset;
   logic [5:0]    Opcode;
   logic          Zero;
   logic          MemReady;
   logic          PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD, MemToReg, Illegal;
   logic [3:0]    ALUSrcBSel;
   logic [2:0]    PCSrcSel, RegDstSel, ALUOpSel;
   logic [3:0]    State;
   logic [CW-1:0] RetireCount;

   int n_cmp = 0;
   int n_bad = 0;

   multicycle_control #(.COUNT_W(CW)) dut (
      .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .IorD(IorD), .MemToReg(MemToReg), .ALUSrcBSel(ALUSrcBSel),
      .PCSrcSel(PCSrcSel), .RegDstSel(RegDstSel), .ALUOpSel(ALUOpSel), .State(State),
      .Illegal(Illegal), .RetireCount(RetireCount)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: instruction paths as lists of states ----------------
   int            m_state = 0;
   int            m_path[$];
   logic [CW-1:0] m_cnt = '0;

   function automatic bit legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
   endfunction

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         m_state = 0;
         m_path.delete();
         m_cnt   = '0;
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         if (MemReady) m_state = 2;
      end else if (m_state == 2) begin
         m_path.delete();
         case (Opcode)
            6'b000000: m_path = '{7, 8};
            6'b100011: m_path = '{3, 4, 5};
            6'b101011: m_path = '{3, 6};
            6'b000100: m_path = '{9};
            6'b000010: m_path = '{10};
            6'b001000: m_path = '{11, 12};
            default:   m_path.delete();
         endcase
         if (m_path.size() == 0) m_state = 1;
         else m_state = m_path.pop_front();
      end else if (!((m_state == 4 || m_state == 6) && !MemReady)) begin
         if (m_path.size() == 0) begin
            m_state = 1;
            m_cnt   = m_cnt + 1'b1;
         end else begin
            m_state = m_path.pop_front();
         end
      end
   end

   // Output table per state: {pcw,irw,mr,mw,rw,iord,m2r,alub[4],pcsrc[3],regdst[3],aluop[3],illegal}
   function automatic logic [20:0] exp_out(input int st, input logic z, input logic rdy,
                                           input logic [5:0] op);
      logic pcw, irw, mr, mw, rw, iord, m2r, ill;
      logic [3:0] alub;
      logic [2:0] pcsrc, regdst, aluop;
      {pcw, irw, mr, mw, rw, iord, m2r, ill} = '0;
      alub = '0; pcsrc = '0; regdst = '0; aluop = '0;
      case (st)
         1:  begin mr = 1; alub = 4'b0010; aluop = 3'b001; pcsrc = 3'b001; pcw = rdy; irw = rdy; end
         2:  begin alub = 4'b1000; aluop = 3'b001; ill = !legal(op); end
         3:  begin alub = 4'b0100; aluop = 3'b001; end
         4:  begin mr = 1; iord = 1; end
         5:  begin rw = 1; m2r = 1; regdst = 3'b001; end
         6:  begin mw = 1; iord = 1; end
         7:  begin alub = 4'b0001; aluop = 3'b100; end
         8:  begin rw = 1; regdst = 3'b010; end
         9:  begin alub = 4'b0001; aluop = 3'b010; pcsrc = 3'b010; pcw = z; end
         10: begin pcsrc = 3'b100; pcw = 1; end
         11: begin alub = 4'b0100; aluop = 3'b001; end
         12: begin rw = 1; regdst = 3'b001; end
         default: ;
      endcase
      return {pcw, irw, mr, mw, rw, iord, m2r, alub, pcsrc, regdst, aluop, ill};
   endfunction

   always @(negedge Clock) begin
      check("state", 32'(State), 32'(m_state));
      check("retire", 32'(RetireCount), 32'(m_cnt));
      check("outputs", 32'({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD, MemToReg,
                            ALUSrcBSel, PCSrcSel, RegDstSel, ALUOpSel, Illegal}),
            32'(exp_out(m_state, Zero, MemReady, Opcode)));
      check("sel_onehot", 32'({$onehot0(ALUSrcBSel), $onehot0(PCSrcSel),
                               $onehot0(RegDstSel), $onehot0(ALUOpSel)}), 32'hF);
      check("rd_wr_excl", 32'(MemRead & MemWrite), 32'h0);
   end

   // ---------------- directed stimulus ----------------
   // One cycle: inputs change just after the rising edge, outputs are read at the falling edge.
   task automatic step(input logic rst, input logic [5:0] op, input logic z, input logic rdy);
      @(posedge Clock);
      #1;
      Reset = rst; Opcode = op; Zero = z; MemReady = rdy;
      @(negedge Clock);
   endtask

   // n cycles; states and MemReady values listed first-cycle-first (MSB side) in hex nibbles / bits.
   task automatic run(input string name, input logic [5:0] op, input logic z, input int n,
                      input logic [15:0] rdy, input logic [63:0] st);
      for (int i = 0; i < n; i++) begin
         step(1'b0, op, z, rdy[n-1-i]);
         check($sformatf("%s_st%0d", name, i), 32'(State), 32'(st[4*(n-1-i) +: 4]));
      end
   endtask

   task automatic beq(input logic z, input logic [CW-1:0] cnt_after);
      step(1'b0, 6'b000100, z, 1'b1);
      step(1'b0, 6'b000100, z, 1'b1);
      step(1'b0, 6'b000100, z, 1'b1);
      check($sformatf("beq%0d_state", z), 32'(State), 32'd9);
      check($sformatf("beq%0d_pcwrite", z), 32'(PCWrite), 32'(z));
      check($sformatf("beq%0d_pcsrc", z), 32'(PCSrcSel), 32'b010);
      step(1'b0, 6'b000100, z, 1'b0);
      check($sformatf("beq%0d_retire", z), 32'(RetireCount), 32'(cnt_after));
   endtask

   initial begin
      Reset = 1'b1; Opcode = '0; Zero = 1'b0; MemReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 6'b000000, 1'b0, 1'b1);
         check("rst_state", 32'(State), 32'd0);
         check("rst_outs", 32'({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcBSel,
                                PCSrcSel, RegDstSel, ALUOpSel, Illegal}), 32'h0);
      end
      step(1'b0, 6'b000000, 1'b0, 1'b1);
      check("init_state", 32'(State), 32'd0);
      check("init_retire", 32'(RetireCount), 32'd0);

      run("rtype", 6'b000000, 1'b0, 5, 16'b11110, 64'h12781);
      check("rtype_retire", 32'(RetireCount), 32'd1);

      run("lw", 6'b100011, 1'b0, 9, 16'b111000110, 64'h123444451);
      check("lw_retire", 32'(RetireCount), 32'd2);

      beq(1'b1, 8'd3);
      beq(1'b0, 8'd4);

      run("sw", 6'b101011, 1'b0, 5, 16'b11110, 64'h12361);
      check("sw_retire", 32'(RetireCount), 32'd5);
      run("addi", 6'b001000, 1'b0, 5, 16'b11110, 64'h12BC1);
      check("addi_retire", 32'(RetireCount), 32'd6);

      step(1'b0, 6'b111111, 1'b0, 1'b1);
      step(1'b0, 6'b111111, 1'b0, 1'b1);
      check("ill_decode", 32'(State), 32'd2);
      check("ill_pulse", 32'(Illegal), 32'd1);
      step(1'b0, 6'b111111, 1'b0, 1'b0);
      check("ill_back", 32'(State), 32'd1);
      check("ill_pulse_end", 32'(Illegal), 32'd0);
      check("ill_retire", 32'(RetireCount), 32'd6);

      run("swstall", 6'b101011, 1'b0, 4, 16'b1110, 64'h1236);
      check("swstall_memwrite", 32'(MemWrite), 32'd1);
      #2 Reset = 1'b1;
      #1;
      check("abort_state", 32'(State), 32'd0);
      check("abort_memwrite", 32'(MemWrite), 32'd0);
      check("abort_retire", 32'(RetireCount), 32'd0);
      step(1'b1, 6'b000010, 1'b0, 1'b1);
      check("abort_hold", 32'(State), 32'd0);
      step(1'b0, 6'b000010, 1'b0, 1'b1);

      for (int k = 0; k < 255; k++) begin
         step(1'b0, 6'b000010, 1'b0, 1'b1);
         step(1'b0, 6'b000010, 1'b0, 1'b1);
         step(1'b0, 6'b000010, 1'b0, 1'b1);
      end
      step(1'b0, 6'b000010, 1'b0, 1'b1);
      check("j_preload", 32'(RetireCount), 32'hFF);
      step(1'b0, 6'b000010, 1'b0, 1'b1);
      step(1'b0, 6'b000010, 1'b0, 1'b1);
      check("j_state", 32'(State), 32'd10);
      check("j_pcsrc", 32'(PCSrcSel), 32'b100);
      check("j_pcwrite", 32'(PCWrite), 32'd1);
      step(1'b0, 6'b000010, 1'b0, 1'b0);
      check("j_wrap", 32'(RetireCount), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
